// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - MIPS program counter and fetch sequencer
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] branch_target_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  input  logic        stall_i,
  input  logic        halt_i,
  output logic        imem_req_o,
  input  logic        imem_ready_i,
  output logic        instr_valid_o,
  output logic        halted_o,
  output logic        err_misalign_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] pend_pc;
  logic        pend_valid;
  logic        in_fetch, advance, redirect, jr_bad, stop;
  logic        load_pc, capture;
  logic [31:0] redirect_pc, next_pc;

  always_comb begin
    in_fetch = (state == FETCH);
    advance  = imem_ready_i & ~stall_i;
    redirect = jr_i | jump_i | branch_taken_i;
    jr_bad   = jr_i & (jr_addr_i[1:0] != 2'b00);
    stop     = jr_bad | halt_i;
    load_pc  = in_fetch & ~stop & advance;
    capture  = in_fetch & ~stop & ~advance & redirect;

    if (jr_i)
      redirect_pc = jr_addr_i;
    else if (jump_i)
      redirect_pc = {pc_plus4_i[31:28], jump_index_i, 2'b00};
    else
      redirect_pc = branch_target_i;

    // A fresh redirect outranks a buffered one; the buffer outranks sequential flow.
    if (redirect)
      next_pc = redirect_pc;
    else if (pend_valid)
      next_pc = pend_pc;
    else
      next_pc = pc_plus4_i;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT:    state_nx = FETCH;
      FETCH:   if (stop) state_nx = HALT;
      HALT:    state_nx = HALT;
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc_o           <= RESET_PC;
      pend_pc        <= 32'h0;
      pend_valid     <= 1'b0;
      instr_valid_o  <= 1'b0;
      err_misalign_o <= 1'b0;
      fetch_count_o  <= 32'h0;
    end else begin
      state         <= state_nx;
      instr_valid_o <= load_pc;
      if (in_fetch && jr_bad)
        err_misalign_o <= 1'b1;
      if (load_pc) begin
        pc_o          <= next_pc;
        pend_valid    <= 1'b0;
        fetch_count_o <= fetch_count_o + 32'd1;
      end else if (capture) begin
        pend_pc    <= redirect_pc;
        pend_valid <= 1'b1;
      end
    end
  end

  assign imem_req_o = (state == FETCH);
  assign halted_o   = (state == HALT);

endmodule
